// File: rtl/frame_gen_tx_if.sv
// rtl/frame_gen_tx_if.sv - MAC TX byte stream (data/dvld/ack) between generator and MAC
interface frame_gen_tx_if;
  logic [7:0] mac_tx_data;
  logic       mac_tx_dvld;
  logic       mac_tx_ack;

  modport master (output mac_tx_data, output mac_tx_dvld, input mac_tx_ack);
  modport slave  (input mac_tx_data, input mac_tx_dvld, output mac_tx_ack);
endinterface

// File: rtl/frame_gen_tx.sv
// rtl/frame_gen_tx.sv - test-frame generator (seq number + TX timestamp) driving the MAC TX port
module frame_gen_tx #(
  parameter logic [47:0] DST_MAC     = 48'hFFFFFFFFFFFF,
  parameter logic [47:0] SRC_MAC     = 48'h004e46324300,
  parameter logic [15:0] ETH_TYPE    = 16'h88B5,
  parameter int          MAX_LEN     = 1518,
  parameter int          LEN_W       = 14,
  parameter int          ACK_TIMEOUT = 64,
  parameter logic [7:0]  PAD_BYTE    = 8'h00
) (
  input  logic               tx_clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic [15:0]        cfg_frame_count,
  input  logic [LEN_W-1:0]   cfg_frame_len,
  input  logic [15:0]        cfg_gap,
  input  logic               cfg_payload_mode,
  output logic               conf_tx_en,
  output logic               conf_tx_jumbo_en,
  output logic               conf_tx_no_gen_crc,
  frame_gen_tx_if.master     tx,
  output logic               busy,
  output logic               frame_done,
  output logic               ack_timeout_err,
  output logic [31:0]        frames_sent
);

  localparam int               TO_W    = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(ACK_TIMEOUT - 1);
  localparam logic [LEN_W-1:0] MIN_L   = LEN_W'(60);
  localparam logic [LEN_W-1:0] MAX_L   = LEN_W'(MAX_LEN);
  localparam logic             JUMBO   = (MAX_LEN > 1518);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_ACK, S_DATA, S_GAP} state_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d, idx_q, idx_d;
  logic [15:0]      gap_q, gap_d, gap_cnt_q, gap_cnt_d;
  logic [15:0]      count_q, count_d, run_sent_q, run_sent_d;
  logic             mode_q, mode_d, stop_pend_q, stop_pend_d;
  logic [TO_W-1:0]  wait_q, wait_d;
  logic [31:0]      ts_cnt_q, ts_cap_q, ts_cap_d, sent_q, sent_d;
  logic [7:0]       data_q, data_d;
  logic             dvld_q, dvld_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic             conf_en_q, conf_jumbo_q;

  // Bytes 0..21 come from the header vector; the rest is payload.
  function automatic logic [7:0] frame_byte(input logic [LEN_W-1:0] i,
                                            input logic [31:0] seq,
                                            input logic [31:0] ts,
                                            input logic mode);
    logic [175:0] hdr;
    logic [7:0]   base;
    hdr  = {DST_MAC, SRC_MAC, ETH_TYPE, seq, ts};
    base = 8'd175 - {i[4:0], 3'b000};
    if (i < LEN_W'(22))
      return hdr[base -: 8];
    else if (mode)
      return PAD_BYTE;
    else
      return i[7:0] - 8'd22;
  endfunction

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    gap_d       = gap_q;
    count_d     = count_q;
    mode_d      = mode_q;
    idx_d       = idx_q;
    gap_cnt_d   = gap_cnt_q;
    run_sent_d  = run_sent_q;
    stop_pend_d = stop_pend_q;
    wait_d      = wait_q;
    ts_cap_d    = ts_cap_q;
    sent_d      = sent_q;
    data_d      = data_q;
    dvld_d      = dvld_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (cfg_frame_len > MAX_L)      len_d = MAX_L;
          else if (cfg_frame_len < MIN_L) len_d = MIN_L;
          else                            len_d = cfg_frame_len;
          gap_d       = (cfg_gap == 16'd0) ? 16'd1 : cfg_gap;
          count_d     = cfg_frame_count;
          mode_d      = cfg_payload_mode;
          run_sent_d  = 16'd0;
          stop_pend_d = 1'b0;
          wait_d      = '0;
          busy_d      = 1'b1;
          dvld_d      = 1'b1;
          data_d      = DST_MAC[47:40];
          state_d     = S_WAIT_ACK;
        end
      end
      S_WAIT_ACK: begin
        if (stop) begin
          dvld_d  = 1'b0;
          data_d  = 8'h00;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else if (tx.mac_tx_ack) begin
          ts_cap_d = ts_cnt_q;
          idx_d    = LEN_W'(1);
          data_d   = DST_MAC[39:32];
          state_d  = S_DATA;
        end else if (wait_q == TO_LAST) begin
          // Aborted frame: neither counted nor does it advance the sequence.
          dvld_d    = 1'b0;
          data_d    = 8'h00;
          err_d     = 1'b1;
          gap_cnt_d = 16'd0;
          state_d   = S_GAP;
        end else begin
          wait_d = wait_q + TO_W'(1);
        end
      end
      S_DATA: begin
        if (stop) stop_pend_d = 1'b1;
        if (idx_q == len_q - LEN_W'(1)) begin
          dvld_d     = 1'b0;
          data_d     = 8'h00;
          done_d     = 1'b1;
          sent_d     = sent_q + 32'd1;
          run_sent_d = run_sent_q + 16'd1;
          if (stop || stop_pend_q ||
              (count_q != 16'd0 && run_sent_q + 16'd1 == count_q)) begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            gap_cnt_d = 16'd0;
            state_d   = S_GAP;
          end
        end else begin
          idx_d  = idx_q + LEN_W'(1);
          data_d = frame_byte(idx_q + LEN_W'(1), sent_q, ts_cap_q, mode_q);
        end
      end
      S_GAP: begin
        if (stop) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else if (gap_cnt_q == gap_q - 16'd1) begin
          dvld_d  = 1'b1;
          data_d  = DST_MAC[47:40];
          wait_d  = '0;
          state_d = S_WAIT_ACK;
        end else begin
          gap_cnt_d = gap_cnt_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge tx_clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      len_q        <= '0;
      gap_q        <= '0;
      count_q      <= '0;
      mode_q       <= 1'b0;
      idx_q        <= '0;
      gap_cnt_q    <= '0;
      run_sent_q   <= '0;
      stop_pend_q  <= 1'b0;
      wait_q       <= '0;
      ts_cnt_q     <= '0;
      ts_cap_q     <= '0;
      sent_q       <= '0;
      data_q       <= '0;
      dvld_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      conf_en_q    <= 1'b0;
      conf_jumbo_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      gap_q        <= gap_d;
      count_q      <= count_d;
      mode_q       <= mode_d;
      idx_q        <= idx_d;
      gap_cnt_q    <= gap_cnt_d;
      run_sent_q   <= run_sent_d;
      stop_pend_q  <= stop_pend_d;
      wait_q       <= wait_d;
      ts_cnt_q     <= ts_cnt_q + 32'd1;
      ts_cap_q     <= ts_cap_d;
      sent_q       <= sent_d;
      data_q       <= data_d;
      dvld_q       <= dvld_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      conf_en_q    <= 1'b1;
      conf_jumbo_q <= JUMBO;
    end
  end

  assign tx.mac_tx_data     = data_q;
  assign tx.mac_tx_dvld     = dvld_q;
  assign busy               = busy_q;
  assign frame_done         = done_q;
  assign ack_timeout_err    = err_q;
  assign frames_sent        = sent_q;
  assign conf_tx_en         = conf_en_q;
  assign conf_tx_jumbo_en   = conf_jumbo_q;
  assign conf_tx_no_gen_crc = 1'b0;

endmodule

// File: tb/tb_frame_gen_tx.sv
// tb/tb_frame_gen_tx.sv - randomized self-checking bench for frame_gen_tx against a frame-layout model
module tb_frame_gen_tx;
  localparam logic [47:0] DST  = 48'hFFFFFFFFFFFF;
  localparam logic [47:0] SRC  = 48'h004e46324300;
  localparam logic [15:0] ETYP = 16'h88B5;

  logic        tx_clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [15:0] cfg_frame_count = '0;
  logic [13:0] cfg_frame_len = '0;
  logic [15:0] cfg_gap = '0;
  logic        cfg_payload_mode = 1'b0;
  logic        conf_tx_en, conf_tx_jumbo_en, conf_tx_no_gen_crc;
  logic        busy, frame_done, ack_timeout_err;
  logic [31:0] frames_sent;

  frame_gen_tx_if tx_if();

  frame_gen_tx dut (
    .tx_clk(tx_clk), .reset(reset), .start(start), .stop(stop),
    .cfg_frame_count(cfg_frame_count), .cfg_frame_len(cfg_frame_len),
    .cfg_gap(cfg_gap), .cfg_payload_mode(cfg_payload_mode),
    .conf_tx_en(conf_tx_en), .conf_tx_jumbo_en(conf_tx_jumbo_en),
    .conf_tx_no_gen_crc(conf_tx_no_gen_crc), .tx(tx_if),
    .busy(busy), .frame_done(frame_done), .ack_timeout_err(ack_timeout_err),
    .frames_sent(frames_sent)
  );

  always #5 tx_clk = ~tx_clk;

  int edge_cnt = 0;
  always @(posedge tx_clk) edge_cnt++;

  int          checks = 0;
  int          errors = 0;
  int          base = 0;
  int          sent_model = 0;
  logic [7:0]  fb [0:2047];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int clamp_len(input int l);
    if (l > 1518) return 1518;
    if (l < 60) return 60;
    return l;
  endfunction

  function automatic int clamp_gap(input int g);
    return (g < 1) ? 1 : g;
  endfunction

  function automatic logic [7:0] exp_byte(input int i, input logic [31:0] seq,
                                          input logic [31:0] ts, input bit mode);
    logic [175:0] h;
    h = {DST, SRC, ETYP, seq, ts};
    if (i < 22) return h[175 - 8*i -: 8];
    if (mode) return 8'h00;
    return 8'((i - 22) % 256);
  endfunction

  task automatic check_frame(input string tag, input int n, input int exp_len,
                             input logic [31:0] seq, input logic [31:0] ts, input bit mode);
    int nbad;
    nbad = 0;
    check({tag, "_len"}, n, exp_len);
    check({tag, "_seq"}, {fb[14], fb[15], fb[16], fb[17]}, seq);
    check({tag, "_ts"}, {fb[18], fb[19], fb[20], fb[21]}, ts);
    for (int i = 0; i < n && i < 2048; i++)
      if (fb[i] !== exp_byte(i, seq, ts, mode)) nbad++;
    check({tag, "_bad_bytes"}, nbad, 0);
  endtask

  task automatic pulse_start(input bit with_stop);
    start = 1'b1;
    stop  = with_stop;
    @(negedge tx_clk);
    start = 1'b0;
    stop  = 1'b0;
  endtask

  // Acts as the MAC: waits for dvld, acks after ack_dly cycles, collects bytes.
  task automatic recv_frame(input int ack_dly, input int stop_at, input int rst_at,
                            output int gap_low, output int n, output logic [31:0] ts_exp,
                            output logic done, output logic [31:0] sent);
    gap_low = 0; n = 0; ts_exp = '0; done = 1'b0; sent = '0;
    while (!tx_if.mac_tx_dvld && gap_low < 400) begin
      @(negedge tx_clk);
      gap_low++;
    end
    check("dvld_rise_seen", tx_if.mac_tx_dvld, 1'b1);
    if (!tx_if.mac_tx_dvld) return;
    fb[0] = tx_if.mac_tx_data;
    for (int d = 0; d < ack_dly; d++) @(negedge tx_clk);
    check("byte0_held", {tx_if.mac_tx_dvld, tx_if.mac_tx_data}, {1'b1, DST[47:40]});
    tx_if.mac_tx_ack = 1'b1;
    ts_exp = 32'(edge_cnt - base);
    @(negedge tx_clk);
    tx_if.mac_tx_ack = 1'b0;
    n = 1;
    while (tx_if.mac_tx_dvld && n < 2048) begin
      fb[n] = tx_if.mac_tx_data;
      if (n == stop_at) stop = 1'b1;
      if (n == rst_at) begin
        #2 reset = 1'b1;
        #1;
        check("rst_dvld", tx_if.mac_tx_dvld, 1'b0);
        check("rst_data", tx_if.mac_tx_data, 8'h00);
        check("rst_busy", busy, 1'b0);
        n++;
        return;
      end
      n++;
      @(negedge tx_clk);
      stop = 1'b0;
    end
    done = frame_done;
    sent = frames_sent;
  endtask

  task automatic run_frames(input string tag, input int count, input int len,
                            input int gap, input bit mode, input int ackd);
    int g, n, ad;
    logic [31:0] ts, sent;
    logic done;
    cfg_frame_count  = 16'(count);
    cfg_frame_len    = 14'(len);
    cfg_gap          = 16'(gap);
    cfg_payload_mode = mode;
    pulse_start(1'b0);
    // Configuration must be latched at start; disturb it for the rest of the run.
    cfg_frame_len    = 14'($urandom);
    cfg_gap          = 16'($urandom);
    cfg_frame_count  = 16'($urandom);
    cfg_payload_mode = ~mode;
    for (int f = 0; f < count; f++) begin
      ad = (ackd < 0) ? int'($urandom_range(0, 20)) : ackd;
      recv_frame(ad, -1, -1, g, n, ts, done, sent);
      if (f > 0) check({tag, "_gap"}, g, clamp_gap(gap));
      check_frame(tag, n, clamp_len(len), 32'(sent_model), ts, mode);
      sent_model++;
      check({tag, "_done"}, done, 1'b1);
      check({tag, "_sent"}, sent, 32'(sent_model));
      check({tag, "_busy"}, busy, (f == count - 1) ? 1'b0 : 1'b1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int g, n, hi, ad;
    logic [31:0] ts, sent;
    logic done;
    logic [31:0] seq0;

    tx_if.mac_tx_ack = 1'b0;
    repeat (2) @(negedge tx_clk);
    check("rst_state_dvld", tx_if.mac_tx_dvld, 1'b0);
    check("rst_state_data", tx_if.mac_tx_data, 8'h00);
    check("rst_state_busy", busy, 1'b0);
    check("rst_state_conf_en", conf_tx_en, 1'b0);
    check("rst_state_sent", frames_sent, 32'd0);
    reset = 1'b0;
    base  = edge_cnt;
    @(negedge tx_clk);
    check("conf_tx_en", conf_tx_en, 1'b1);
    check("conf_jumbo", conf_tx_jumbo_en, 1'b0);
    check("conf_no_crc", conf_tx_no_gen_crc, 1'b0);

    run_frames("basic", 2, 60, 12, 1'b0, 3);
    run_frames("short", 1, 20, 4, 1'b0, 0);
    run_frames("long", 1, 4000, 4, 1'b0, 5);
    check("long_b277", fb[277], 8'hFF);
    check("long_b278", fb[278], 8'h00);

    // Ack withheld: abort after the timeout, then the retry reuses the sequence.
    cfg_frame_count = 16'd1; cfg_frame_len = 14'd64; cfg_gap = 16'd3; cfg_payload_mode = 1'b1;
    seq0 = 32'(sent_model);
    pulse_start(1'b0);
    hi = 0;
    while (tx_if.mac_tx_dvld && hi < 200) begin
      hi++;
      @(negedge tx_clk);
    end
    check("to_dvld_cycles", hi, 64);
    check("to_err", ack_timeout_err, 1'b1);
    check("to_sent", frames_sent, seq0);
    check("to_busy", busy, 1'b1);
    @(negedge tx_clk);
    check("to_err_pulse", ack_timeout_err, 1'b0);
    recv_frame(2, -1, -1, g, n, ts, done, sent);
    check("to_gap", g + 1, 3);
    check_frame("to_retry", n, 64, seq0, ts, 1'b1);
    sent_model++;
    check("to_retry_done", done, 1'b1);

    // Continuous run, stop pulsed during DATA.
    cfg_frame_count = 16'd0; cfg_frame_len = 14'd100; cfg_gap = 16'd5; cfg_payload_mode = 1'b0;
    pulse_start(1'b0);
    recv_frame(1, -1, -1, g, n, ts, done, sent);
    check_frame("cont0", n, 100, 32'(sent_model), ts, 1'b0);
    sent_model++;
    check("cont0_busy", busy, 1'b1);
    recv_frame(4, 30, -1, g, n, ts, done, sent);
    check("cont1_gap", g, 5);
    check_frame("cont1", n, 100, 32'(sent_model), ts, 1'b0);
    sent_model++;
    check("cont1_done", done, 1'b1);
    check("cont1_busy", busy, 1'b0);
    hi = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge tx_clk);
      if (tx_if.mac_tx_dvld) hi++;
    end
    check("stop_no_dvld", hi, 0);
    check("stop_sent", frames_sent, 32'(sent_model));

    for (int r = 0; r < 4; r++) begin
      run_frames("rnd", int'($urandom_range(1, 3)), int'($urandom_range(0, 1700)),
                 int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), -1);
      repeat (3) @(negedge tx_clk);
      check("rnd_idle_dvld", tx_if.mac_tx_dvld, 1'b0);
    end

    // Asynchronous reset in the middle of a frame.
    cfg_frame_count = 16'd0; cfg_frame_len = 14'd100; cfg_gap = 16'd2; cfg_payload_mode = 1'b0;
    pulse_start(1'b0);
    recv_frame(2, -1, 40, g, n, ts, done, sent);
    repeat (3) @(negedge tx_clk);
    check("rst_mid_sent", frames_sent, 32'd0);
    check("rst_mid_conf_en", conf_tx_en, 1'b0);
    reset = 1'b0;
    base  = edge_cnt;
    sent_model = 0;
    @(negedge tx_clk);
    check("rel_conf_en", conf_tx_en, 1'b1);
    while ((edge_cnt - base) < 32'h1E0) @(negedge tx_clk);

    // start and stop together in IDLE: start wins; ack lands at ts = 0x1F4.
    cfg_frame_count = 16'd1; cfg_frame_len = 14'd60; cfg_gap = 16'd1; cfg_payload_mode = 1'b0;
    pulse_start(1'b1);
    ad = 32'h1F4 - (edge_cnt - base);
    recv_frame(ad, -1, -1, g, n, ts, done, sent);
    check("ts_1f4", {fb[18], fb[19], fb[20], fb[21]}, 32'h0000_01F4);
    check_frame("fresh", n, 60, 32'd0, ts, 1'b0);
    check("fresh_done", done, 1'b1);
    check("fresh_sent", sent, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/frame_gen_tx.md
Name: frame_gen_tx

Overview:
Parametrised test-frame generator that drives the 8-bit MAC TX interface (data/dvld/ack) for delay measurement.
- Sends a programmable number of Ethernet frames with runtime-selected length and inter-frame gap.
- Each frame carries a 32-bit sequence number and a 32-bit transmit timestamp.
- Sits between the control/register block and the MAC TX port.

Parameters:
DST_MAC, 48'hFFFFFFFFFFFF, destination MAC, bytes 0-5, MSB first
SRC_MAC, 48'h004e46324300, source MAC, bytes 6-11
ETH_TYPE, 16'h88B5, EtherType, bytes 12-13
MAX_LEN, 1518, largest frame length in bytes, excluding CRC
LEN_W, 14, width of cfg_frame_len
ACK_TIMEOUT, 64, cycles to wait for mac_tx_ack before abort
PAD_BYTE, 8'h00, payload byte when cfg_payload_mode=1

Ports:
reset  in  1  asynchronous, active-high
tx_clk  in  1  transmit clock; all logic on its rising edge
start  in  1  one-cycle pulse; honoured only in IDLE
stop  in  1  pulse; finish current frame, then go to IDLE
cfg_frame_count  in  16  frames per run; 0 = continuous until stop
cfg_frame_len  in  LEN_W  frame length in bytes, excluding CRC
cfg_gap  in  16  idle cycles between frames
cfg_payload_mode  in  1  0 = incrementing payload, 1 = PAD_BYTE
conf_tx_en  out  1  MAC TX enable
conf_tx_jumbo_en  out  1  MAC jumbo enable
conf_tx_no_gen_crc  out  1  MAC CRC-suppress; always 0, MAC appends CRC
mac_tx_data  out  8  frame byte
mac_tx_dvld  out  1  frame byte valid
mac_tx_ack  in  1  MAC accepted first byte
busy  out  1  run in progress
frame_done  out  1  one-cycle pulse after the last byte of a frame is sent
ack_timeout_err  out  1  one-cycle pulse on frame abort
frames_sent  out  32  frames completed since reset; wraps

Behaviour:
- Reset (asynchronous, takes effect mid-frame too):
  - All outputs 0; state IDLE; timestamp counter 0.
  - mac_tx_dvld drops to 0 immediately; no partial frame resumes.
- First clock after reset deassert: conf_tx_en=1; conf_tx_jumbo_en=(MAX_LEN>1518); conf_tx_no_gen_crc=0. These then hold.
- ts_cnt: 32-bit free-running counter, +1 every cycle, wraps.
- States: IDLE, WAIT_ACK, DATA, GAP. All outputs are registered.
- IDLE:
  - start=1 latches len, gap, count and mode; sets busy=1; next state is WAIT_ACK.
  - Length clamp: len = max(60, min(cfg_frame_len, MAX_LEN)).
  - Gap clamp: gap = max(1, cfg_gap).
  - Latched values stay fixed for the whole run.
- WAIT_ACK:
  - dvld=1, data=byte0 held.
  - On the edge where ack=1: byte0 is consumed, ts_cnt is captured as the frame timestamp, state goes to DATA.
  - byte1 appears the cycle after ack.
  - If ack is still 0 after ACK_TIMEOUT cycles: dvld=0, ack_timeout_err pulses, state goes to GAP. The frame is not counted and the sequence is not advanced.
- DATA:
  - One byte per cycle, bytes 1..len-1; the MAC applies no backpressure after ack.
  - dvld deasserts the cycle after byte len-1.
  - On that cycle: frame_done pulses and frames_sent increments.
- Frame layout (big-endian fields):
  - 0-5: DST_MAC
  - 6-11: SRC_MAC
  - 12-13: ETH_TYPE
  - 14-17: sequence = frames_sent value at frame start
  - 18-21: captured timestamp
  - 22..len-1: payload; byte (i-22) mod 256 in mode 0, PAD_BYTE in mode 1
- After a frame ends:
  - Go to IDLE (busy=0) if a stop was pending or the run count is reached; otherwise go to GAP.
  - Timed-out frames do not count toward the run count.
- GAP: dvld=0 for exactly gap cycles, then WAIT_ACK.
- stop:
  - In GAP or WAIT_ACK: go to IDLE on the next edge and drop dvld.
  - In DATA: latched as pending and honoured at frame end.
- start while busy is ignored. If start and stop arrive together in IDLE, start wins and stop is ignored.
- ack seen outside WAIT_ACK is ignored.

Test Plan:
- count=2, len=60, gap=12, mode=0, ack 3 cycles after dvld → two 60-byte frames. Frame 0: bytes 14-17 = 00000000, bytes 22-59 = 00..25. Exactly 12 dvld-low cycles between frames; frames_sent=2; busy falls after frame_done.
- len=20 → clamped to 60 bytes. len=4000 with MAX_LEN=1518 → 1518 bytes. Check byte 22+255 = FF and the payload wraps to 00.
- ack held 0 → after 64 cycles dvld=0 and ack_timeout_err pulses. Next frame carries the same sequence number; frames_sent is unchanged.
- count=0 continuous, stop pulsed at DATA byte 30 → frame completes all len bytes, then IDLE with no further dvld.
- Reset asserted at DATA byte 40 → dvld and data go to 0 asynchronously. After release: conf_tx_en=1 one cycle later, then a fresh start gives sequence 0.
- Timestamp check: bytes 18-21 equal ts_cnt sampled at the ack edge. With ack at ts=0x000001F4, the bytes read 00 00 01 F4.
